// File: rtl/bn_affine.sv
// bn_affine: per-channel batch-norm affine stage, y = sat(((x*k) >>> FRAC_BITS) + b), 2-cycle pipeline.
// Optional build macro BN_ROUND_EN: round half up before the shift instead of flooring.
module bn_affine #(
    parameter int DATA_WIDTH  = 16,
    parameter int PARA_WIDTH  = 16,
    parameter int CHANNEL_NUM = 128,
    parameter int FRAC_BITS   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              para_start,
    input  logic                              para_in_valid,
    input  logic [PARA_WIDTH-1:0]             para_in,
    output logic                              param_ready,
    input  logic                              data_in_valid,
    input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] data_in,
    output logic [DATA_WIDTH*CHANNEL_NUM-1:0] data_out,
    output logic                              data_out_valid,
    output logic                              drop_err
);
    localparam int CW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int TW = PW - FRAC_BITS + 1;
    localparam logic [CW-1:0] LAST = CW'(CHANNEL_NUM - 1);
`ifdef BN_ROUND_EN
    localparam logic [PW:0] RND = (PW + 1)'(1) << (FRAC_BITS - 1);
`endif

    typedef enum logic [1:0] {IDLE, LOAD_K, LOAD_B, READY} state_t;

    state_t                        state, next_state;
    logic   [CW-1:0]               cnt, next_cnt;
    logic                          k_we, b_we, accept, v1;
    logic signed [PARA_WIDTH-1:0]  k_bank [CHANNEL_NUM];
    logic signed [PARA_WIDTH-1:0]  b_bank [CHANNEL_NUM];
    logic signed [PW-1:0]          prod   [CHANNEL_NUM];
    logic [DATA_WIDTH*CHANNEL_NUM-1:0] sat_out;

    assign accept = data_in_valid && param_ready;

    // FSM state, load counter and the registered ready flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            param_ready <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= next_cnt;
            param_ready <= (next_state == READY);
        end
    end

    // next state: para_start wins over any word arriving in the same cycle
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        if (para_start) begin
            next_state = LOAD_K;
            next_cnt   = '0;
        end else if (para_in_valid && (state == LOAD_K || state == LOAD_B)) begin
            next_cnt = (cnt == LAST) ? '0 : cnt + CW'(1);
            if (cnt == LAST)
                next_state = (state == LOAD_K) ? LOAD_B : READY;
        end
    end

    // bank write strobes decoded from the current state
    always_comb begin
        k_we = para_in_valid && !para_start && state == LOAD_K;
        b_we = para_in_valid && !para_start && state == LOAD_B;
    end

    // scale and bias register banks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                k_bank[c] <= '0;
                b_bank[c] <= '0;
            end
        end else begin
            if (k_we) k_bank[cnt] <= para_in;
            if (b_we) b_bank[cnt] <= para_in;
        end
    end

    // sticky flag for samples that arrive before the parameter set is complete
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_err <= 1'b0;
        else if (data_in_valid && !param_ready)
            drop_err <= 1'b1;
    end

    // stage 1: full-precision product per channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            for (int c = 0; c < CHANNEL_NUM; c++)
                prod[c] <= '0;
        end else begin
            v1 <= accept;
            if (accept)
                for (int c = 0; c < CHANNEL_NUM; c++)
                    prod[c] <= PW'($signed(data_in[c*DATA_WIDTH +: DATA_WIDTH])) * PW'(k_bank[c]);
        end
    end

    // stage 2 datapath: shift, bias add and saturation per lane
    for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_lane
        logic signed [PW:0]   pe;
        logic signed [TW-1:0] s, t;
        logic                 fits;
`ifdef BN_ROUND_EN
        assign pe = {prod[g][PW-1], prod[g]} + RND;
`else
        assign pe = {prod[g][PW-1], prod[g]};
`endif
        assign s    = TW'(pe >>> FRAC_BITS);
        assign t    = s + TW'(b_bank[g]);
        assign fits = (&t[TW-1:DATA_WIDTH-1]) || !(|t[TW-1:DATA_WIDTH-1]);
        assign sat_out[g*DATA_WIDTH +: DATA_WIDTH] = fits ? t[DATA_WIDTH-1:0]
                                                          : {t[TW-1], {(DATA_WIDTH-1){!t[TW-1]}}};
    end

    // stage 2 register: output holds its value between valid pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= v1;
            if (v1) data_out <= sat_out;
        end
    end
endmodule

// File: tb/tb_bn_affine.sv
// tb_bn_affine: scoreboard bench for bn_affine; follows BN_ROUND_EN when it is defined.
module tb_bn_affine;
    localparam int W = 16;
    localparam int C = 128;
    localparam int F = 8;
`ifdef BN_ROUND_EN
    localparam logic [15:0] EXP_NEG3 = 16'hFFFF;
`else
    localparam logic [15:0] EXP_NEG3 = 16'hFFFE;
`endif

    typedef logic [W*C-1:0] vec_t;
    typedef struct { vec_t d; int t; } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        para_start = 1'b0;
    logic        para_in_valid = 1'b0;
    logic [15:0] para_in = '0;
    logic        param_ready;
    logic        data_in_valid = 1'b0;
    vec_t        data_in = '0;
    vec_t        data_out;
    logic        data_out_valid;
    logic        drop_err;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [15:0] mk[C], mb[C], nk[C], nb[C];
    bit          mready = 0;

    bn_affine #(.DATA_WIDTH(W), .PARA_WIDTH(W), .CHANNEL_NUM(C), .FRAC_BITS(F)) dut (
        .clk(clk), .rst(rst), .para_start(para_start), .para_in_valid(para_in_valid),
        .para_in(para_in), .param_ready(param_ready), .data_in_valid(data_in_valid),
        .data_in(data_in), .data_out(data_out), .data_out_valid(data_out_valid),
        .drop_err(drop_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic vec_t rep(logic [15:0] v);
        vec_t r;
        for (int c = 0; c < C; c++) r[c*W +: W] = v;
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int c = 0; c < C; c++) r[c*W +: W] = 16'($urandom);
        return r;
    endfunction

    // reference arithmetic: exact integer product, floor (or rounded) divide by 2^F, add bias, clamp
    function automatic logic [15:0] ref_lane(logic [15:0] x, logic [15:0] k, logic [15:0] b);
        longint v;
        v = longint'($signed(x)) * longint'($signed(k));
`ifdef BN_ROUND_EN
        v = v + (longint'(1) << (F - 1));
`endif
        v = v >>> F;
        v = v + longint'($signed(b));
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    function automatic vec_t model(vec_t x);
        vec_t r;
        for (int c = 0; c < C; c++) r[c*W +: W] = ref_lane(x[c*W +: W], mk[c], mb[c]);
        return r;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic chk_vec(string n, vec_t act, vec_t exp);
        int lane;
        total++;
        if (act !== exp) begin
            bad++;
            lane = 0;
            for (int c = C - 1; c >= 0; c--) if (act[c*W +: W] !== exp[c*W +: W]) lane = c;
            $display("FAIL %s: lane %0d got %h expected %h (cycle %0d)", n, lane,
                     act[lane*W +: W], exp[lane*W +: W], cyc);
        end
    endtask

    // monitor: every output pulse must match the oldest expected response and its arrival cycle
    always @(negedge clk) begin
        exp_t e;
        if (!rst && data_out_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got valid output, expected none (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk_vec("data_out", data_out, e.d);
                chk("latency", 32'(cyc), 32'(e.t));
            end
        end
    end

    task automatic next_slot();
        @(posedge clk);
        #1;
        para_start    = 1'b0;
        para_in_valid = 1'b0;
        data_in_valid = 1'b0;
    endtask

    task automatic send(vec_t x, vec_t e);
        next_slot();
        data_in       = x;
        data_in_valid = 1'b1;
        if (mready) q.push_back('{d: e, t: cyc + 2});
    endtask

    task automatic send_rand();
        vec_t x;
        x = rand_vec();
        send(x, model(x));
    endtask

    // full parameter load; the start slot also carries a word that must be ignored
    task automatic load(bit gaps);
        next_slot();
        para_start    = 1'b1;
        para_in_valid = 1'b1;
        para_in       = 16'hDEAD;
        mready        = 0;
        next_slot();
        chk("ready_after_start", 32'(param_ready), 32'd0);
        for (int i = 0; i < 2 * C; i++) begin
            if (i > 0) next_slot();
            if (gaps && $urandom_range(0, 3) == 0) next_slot();
            para_in_valid = 1'b1;
            para_in       = (i < C) ? nk[i] : nb[i - C];
            if (i == 2 * C - 1) chk("ready_before_last", 32'(param_ready), 32'd0);
        end
        next_slot();
        chk("ready_rise", 32'(param_ready), 32'd1);
        mready = 1;
        mk     = nk;
        mb     = nb;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) next_slot();
    endtask

    task automatic set_params(logic [15:0] k, logic [15:0] b);
        for (int c = 0; c < C; c++) begin
            nk[c] = k;
            nb[c] = b;
        end
    endtask

    task automatic set_rand_params();
        for (int c = 0; c < C; c++) begin
            nk[c] = 16'($urandom_range(0, 1023)) - 16'd512;
            nb[c] = 16'($urandom);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(param_ready), 32'd0);
        chk("rst_valid", 32'(data_out_valid), 32'd0);
        chk("rst_drop", 32'(drop_err), 32'd0);
        chk_vec("rst_data", data_out, '0);
        rst = 1'b0;

        set_params(16'h0100, 16'h0000);
        load(1);
        send(rep(16'h1234), rep(16'h1234));
        idle(4);
        chk("no_drop", 32'(drop_err), 32'd0);

        set_params(16'h0200, 16'h0100);
        load(0);
        send(rep(16'h7000), rep(16'h7FFF));
        send(rep(16'h9000), rep(16'h8000));
        send(rep(16'h0010), rep(16'h0120));
        idle(4);

        set_params(16'h0080, 16'h0000);
        load(0);
        send(rep(16'hFFFD), rep(EXP_NEG3));
        idle(4);

        set_rand_params();
        load(1);
        for (int i = 0; i < 3; i++) begin
            next_slot();
            para_in_valid = 1'b1;
            para_in       = 16'($urandom);
        end
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) next_slot();
            send_rand();
        end
        idle(4);

        for (int i = 0; i < 3; i++) send_rand();
        set_rand_params();
        load(1);
        send_rand();
        send_rand();
        idle(4);

        next_slot();
        para_start = 1'b1;
        mready     = 0;
        for (int i = 0; i < C + 3; i++) begin
            next_slot();
            para_in_valid = 1'b1;
            para_in       = 16'($urandom);
        end
        next_slot();
        data_in       = rand_vec();
        data_in_valid = 1'b1;
        next_slot();
        chk("drop_set", 32'(drop_err), 32'd1);
        idle(4);
        next_slot();
        rst = 1'b1;
        #2;
        chk("rst2_drop", 32'(drop_err), 32'd0);
        chk("rst2_ready", 32'(param_ready), 32'd0);
        chk_vec("rst2_data", data_out, '0);
        next_slot();
        rst = 1'b0;

        set_params(16'h0300, 16'h0005);
        next_slot();
        para_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_slot();
            para_in_valid = 1'b1;
            para_in       = 16'h7777;
        end
        next_slot();
        rst = 1'b1;
        next_slot();
        rst = 1'b0;
        for (int c = 0; c < C; c++) begin
            nk[c] = 16'h0100 + 16'(c);
            nb[c] = 16'h0000;
        end
        load(1);
        send(rep(16'h0001), rep(16'h0001));
        for (int i = 0; i < 3; i++) send_rand();

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d outputs still pending, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
